// File: rtl/sd_dat_pkg.sv
// Shared definitions for the DAT-side word FIFO bridge: handshake FSM
// encoding, default word width and direction codes.
package sd_dat_pkg;

  localparam int DATA_W = 32;

  // direction input encoding
  localparam logic DIR_WRITE = 1'b0;  // host -> card: host pushes, DAT pops
  localparam logic DIR_READ  = 1'b1;  // card -> host: DAT pushes, host pops

  // DAT fifo_enable/fifo_ack handshake states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XFER      = 2'd1,
    ST_ACK       = 2'd2,
    ST_WAIT_DROP = 2'd3
  } dat_state_e;

endpackage

// File: rtl/dat_fifo_mem.sv
// DEPTH x DATA_W register array with read/write pointers and an explicit
// occupancy count. The read word is combinational from the read pointer;
// callers decide when a push/pop is legal.
module dat_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // next pointers/count; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // pointer and count registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents are don't-care after a flush so no reset
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/dat_fifo_bridge.sv
// Direction-selected word FIFO between the host bus and the DAT line engine.
//
// DAT handshake: DAT raises fifo_enable_i (level) to request one word. A
// rising edge starts a transfer; once the word is moved fifo_ack_o pulses for
// exactly one cycle, and no further transfer happens until fifo_enable_i has
// dropped. Dropping fifo_enable_i before the word moves cancels the request.
// Host strobes are single-cycle and only honoured in their own direction.
module dat_fifo_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int READY_LEVEL = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   direction,
  input  logic                   host_wr_en,
  input  logic [DATA_W-1:0]      host_wr_data,
  input  logic                   host_rd_en,
  output logic [DATA_W-1:0]      host_rd_data,
  output logic                   host_rd_valid,
  input  logic                   fifo_enable_i,
  input  logic [DATA_W-1:0]      dat_data_i,
  output logic [DATA_W-1:0]      dat_data_o,
  output logic                   fifo_ack_o,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   fifo_ready,
  output logic [ADDR_W:0]        fifo_count,
  output logic                   overflow,
  output logic                   underflow,
  output sd_dat_pkg::dat_state_e dbg_state_o
);

  import sd_dat_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] READY_C = (ADDR_W+1)'(READY_LEVEL);

  dat_state_e        state_q, state_d;
  logic              en_q;
  logic              pend_q, pend_d;
  logic              dir_q;
  logic [DATA_W-1:0] dat_data_q, dat_data_d;
  logic [DATA_W-1:0] host_rd_data_q, host_rd_data_d;
  logic              host_rd_valid_q, host_rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] push_word;
  logic              flush, rise, empty, full;
  logic              dat_pop, dat_push, host_pop, host_push, push, pop;

  // occupancy flags and the per-direction push/pop decisions; a pop may
  // free room for a same-cycle push, but a push never feeds a same-cycle pop
  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    flush     = clear | ((direction != dir_q) & (count != '0));
    rise      = fifo_enable_i & ~en_q;
    host_pop  = (direction == DIR_READ) & host_rd_en & ~empty;
    dat_pop   = (state_q == ST_XFER) & fifo_enable_i & (direction == DIR_WRITE) & ~empty;
    host_push = (direction == DIR_WRITE) & host_wr_en & (~full | dat_pop);
    dat_push  = (state_q == ST_XFER) & fifo_enable_i & (direction == DIR_READ) &
                (~full | host_pop);
    push      = host_push | dat_push;
    pop       = host_pop | dat_pop;
    push_word = (direction == DIR_READ) ? dat_data_i : host_wr_data;
  end

  dat_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (push_word),
    .rd_data_o (rd_word),
    .count_o   (count)
  );

  // DAT handshake next state; a rise seen after the ack is remembered so a
  // quick drop-and-raise is not lost while waiting for the drop
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | (rise & ((state_q == ST_ACK) | (state_q == ST_WAIT_DROP)));
    case (state_q)
      ST_IDLE: begin
        if (rise || pend_q) begin
          state_d = ST_XFER;
          pend_d  = 1'b0;
        end
      end
      ST_XFER: begin
        if (!fifo_enable_i)          state_d = ST_IDLE;
        else if (dat_pop || dat_push) state_d = ST_ACK;
      end
      ST_ACK:       state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: begin
        if (!fifo_enable_i || rise || pend_q) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end
  end

  // data outputs and sticky error flags
  always_comb begin
    dat_data_d      = dat_data_q;
    host_rd_data_d  = host_rd_data_q;
    host_rd_valid_d = 1'b0;
    overflow_d      = overflow_q;
    underflow_d     = underflow_q;
    if (flush) begin
      dat_data_d     = '0;
      host_rd_data_d = '0;
      overflow_d     = 1'b0;
      underflow_d    = 1'b0;
    end else begin
      if (dat_pop) dat_data_d = rd_word;
      if (host_pop) begin
        host_rd_data_d  = rd_word;
        host_rd_valid_d = 1'b1;
      end
      if ((direction == DIR_WRITE) && host_wr_en && !host_push) overflow_d  = 1'b1;
      if ((direction == DIR_READ) && host_rd_en && empty)       underflow_d = 1'b1;
    end
  end

  // state, edge-detect and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      en_q            <= 1'b0;
      pend_q          <= 1'b0;
      dir_q           <= DIR_WRITE;
      dat_data_q      <= '0;
      host_rd_data_q  <= '0;
      host_rd_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      en_q            <= fifo_enable_i;
      pend_q          <= pend_d;
      dir_q           <= direction;
      dat_data_q      <= dat_data_d;
      host_rd_data_q  <= host_rd_data_d;
      host_rd_valid_q <= host_rd_valid_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  assign fifo_ack_o    = (state_q == ST_ACK);
  assign dat_data_o    = dat_data_q;
  assign host_rd_data  = host_rd_data_q;
  assign host_rd_valid = host_rd_valid_q;
  assign fifo_full     = full;
  assign fifo_empty    = empty;
  assign fifo_count    = count;
  assign fifo_ready    = (direction == DIR_READ) ? ((DEPTH_C - count) >= READY_C)
                                                 : (count >= READY_C);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dat_fifo_bridge.sv
// Directed bench for dat_fifo_bridge: stimulus pushes expected output words
// into queues, a negedge monitor pops and compares on every ack/valid.
module tb_dat_fifo_bridge;
  import sd_dat_pkg::*;

  logic        clock = 1'b0;
  logic        reset, clear, direction;
  logic        host_wr_en, host_rd_en, fifo_enable_i;
  logic [31:0] host_wr_data, dat_data_i;
  logic [31:0] host_rd_data, dat_data_o;
  logic        host_rd_valid, fifo_ack_o, fifo_full, fifo_empty, fifo_ready;
  logic [4:0]  fifo_count;
  logic        overflow, underflow;
  dat_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int vld_cnt  = 0;
  logic [31:0] exp_dat_q[$];
  logic [31:0] exp_host_q[$];
  logic [31:0] mon_exp;

  dat_fifo_bridge #(.DATA_W(32), .ADDR_W(4), .READY_LEVEL(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .direction     (direction),
    .host_wr_en    (host_wr_en),
    .host_wr_data  (host_wr_data),
    .host_rd_en    (host_rd_en),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .fifo_enable_i (fifo_enable_i),
    .dat_data_i    (dat_data_i),
    .dat_data_o    (dat_data_o),
    .fifo_ack_o    (fifo_ack_o),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_ready    (fifo_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .underflow     (underflow),
    .dbg_state_o   (dbg_state)
  );

  // clock
  always #5 clock = ~clock;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (fifo_ack_o) begin
      ack_cnt++;
      if (direction == DIR_WRITE) begin
        if (exp_dat_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dat_data_o unexpected ack: got %h expected none", dat_data_o);
        end else begin
          mon_exp = exp_dat_q.pop_front();
          check("dat_data_o", dat_data_o, mon_exp);
        end
      end
    end
    if (host_rd_valid) begin
      vld_cnt++;
      if (exp_host_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL host_rd_data unexpected valid: got %h expected none", host_rd_data);
      end else begin
        mon_exp = exp_host_q.pop_front();
        check("host_rd_data", host_rd_data, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_push(input logic [31:0] d);
    host_wr_data = d;
    host_wr_en   = 1'b1;
    tick();
    host_wr_en   = 1'b0;
  endtask

  // waits for the ack, expecting it two edges after the triggering input
  task automatic wait_ack(input string name);
    int lat;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      host_wr_en = 1'b0;
      if (fifo_ack_o) begin
        lat = k;
        break;
      end
    end
    check({name, " ack latency"}, lat, 32'd2);
  endtask

  task automatic dat_pulse(input string name);
    fifo_enable_i = 1'b1;
    wait_ack(name);
    fifo_enable_i = 1'b0;
    tick();
    tick();
  endtask

  int a0, v0;
  logic [31:0] w;

  initial begin
    reset = 1'b0; clear = 1'b0; direction = DIR_WRITE;
    host_wr_en = 1'b0; host_rd_en = 1'b0; fifo_enable_i = 1'b0;
    host_wr_data = '0; dat_data_i = '0;
    #12;
    // reset values
    check("rst fifo_empty", fifo_empty, 1);
    check("rst fifo_full", fifo_full, 0);
    check("rst fifo_ready", fifo_ready, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst fifo_ack_o", fifo_ack_o, 0);
    check("rst host_rd_valid", host_rd_valid, 0);
    check("rst dat_data_o", dat_data_o, 0);
    check("rst overflow", overflow, 0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset = 1'b1;
    tick();

    // 1: two words host->card
    exp_dat_q.push_back(32'hCAFECAFE);
    exp_dat_q.push_back(32'h0A0BF10A);
    host_push(32'hCAFECAFE);
    host_push(32'h0A0BF10A);
    check("t1 count", fifo_count, 2);
    dat_pulse("t1 word0");
    dat_pulse("t1 word1");
    check("t1 empty", fifo_empty, 1);
    check("t1 dat_data_o hold", dat_data_o, 32'h0A0BF10A);

    // 2: request on empty stalls until a word arrives
    fifo_enable_i = 1'b1;
    a0 = ack_cnt;
    repeat (5) tick();
    check("t2 no ack while empty", ack_cnt - a0, 0);
    check("t2 state stalled", 32'(dbg_state), 32'(ST_XFER));
    exp_dat_q.push_back(32'hABBA01FF);
    host_wr_data = 32'hABBA01FF;
    host_wr_en   = 1'b1;
    wait_ack("t2");
    fifo_enable_i = 1'b0;
    tick(); tick();

    // 3: fill, overflow, drain with pointer wrap
    for (int i = 0; i < 16; i++) begin
      w = {16'hC0DE, 16'(i)};
      exp_dat_q.push_back(w);
      host_push(w);
      if (i == 6) check("t3 ready at 7", fifo_ready, 0);
      if (i == 7) check("t3 ready at 8", fifo_ready, 1);
    end
    check("t3 full", fifo_full, 1);
    check("t3 count 16", fifo_count, 16);
    check("t3 overflow before", overflow, 0);
    host_push(32'hDEAD0017);
    check("t3 overflow", overflow, 1);
    check("t3 count after 17th", fifo_count, 16);
    for (int i = 0; i < 16; i++) dat_pulse("t3 drain");
    check("t3 empty", fifo_empty, 1);
    check("t3 overflow sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3 clear overflow", overflow, 0);
    check("t3 clear dat_data_o", dat_data_o, 0);

    // 4: card->host; ready means free words >= 8
    direction = DIR_READ;
    tick();
    check("t4 ready empty", fifo_ready, 1);
    host_push(32'h12345678);
    check("t4 wrong-dir push ignored", fifo_count, 0);
    check("t4 wrong-dir no overflow", overflow, 0);
    for (int i = 0; i < 9; i++) begin
      w = {16'hD1D1, 16'(i)};
      dat_data_i = w;
      exp_host_q.push_back(w);
      dat_pulse("t4 dat push");
      if (i == 7) begin
        check("t4 count 8", fifo_count, 8);
        check("t4 ready free 8", fifo_ready, 1);
      end
      if (i == 8) begin
        check("t4 count 9", fifo_count, 9);
        check("t4 ready free 7", fifo_ready, 0);
      end
    end
    v0 = vld_cnt;
    host_rd_en = 1'b1;
    repeat (9) tick();
    host_rd_en = 1'b0;
    tick();
    check("t4 valid pulses", vld_cnt - v0, 9);
    check("t4 empty", fifo_empty, 1);
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
    check("t4 underflow", underflow, 1);
    tick();
    check("t4 no valid on empty pop", vld_cnt - v0, 9);

    // 5: enable held high gives one ack; drop in XFER cancels
    direction = DIR_WRITE;
    tick();
    exp_dat_q.push_back(32'h55AA1234);
    exp_dat_q.push_back(32'h66BB5678);
    host_push(32'h55AA1234);
    host_push(32'h66BB5678);
    a0 = ack_cnt;
    fifo_enable_i = 1'b1;
    repeat (10) tick();
    check("t5 one ack held", ack_cnt - a0, 1);
    check("t5 count after held", fifo_count, 1);
    fifo_enable_i = 1'b0;
    tick(); tick();
    dat_pulse("t5 second");
    a0 = ack_cnt;
    fifo_enable_i = 1'b1;
    tick(); tick();
    check("t5 xfer stall", 32'(dbg_state), 32'(ST_XFER));
    fifo_enable_i = 1'b0;
    tick();
    check("t5 cancel idle", 32'(dbg_state), 32'(ST_IDLE));
    exp_dat_q.push_back(32'h0BADF00D);
    host_push(32'h0BADF00D);
    tick(); tick();
    check("t5 no ack after cancel", ack_cnt - a0, 0);
    check("t5 count unchanged", fifo_count, 1);
    dat_pulse("t5 drain");

    // 6: async reset in ACK, then direction flip flush
    host_push(32'hA1A1A1A1);
    host_push(32'hA2A2A2A2);
    fifo_enable_i = 1'b1;
    wait_ack("t6");
    #1 reset = 1'b0;
    #1;
    check("t6 ack cleared", fifo_ack_o, 0);
    check("t6 count cleared", fifo_count, 0);
    check("t6 dat_data_o cleared", dat_data_o, 0);
    fifo_enable_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    host_push(32'h00000001);
    host_push(32'h00000002);
    host_push(32'h00000003);
    check("t6 count 3", fifo_count, 3);
    direction = DIR_READ;
    tick();
    check("t6 flip count", fifo_count, 0);
    check("t6 flip empty", fifo_empty, 1);
    check("t6 flip ready", fifo_ready, 1);
    tick();

    check("dat queue drained", exp_dat_q.size(), 0);
    check("host queue drained", exp_host_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
